blob_tracker: RTL and testbench

BLOB_TRACKER -- requirements
Module: blob_tracker

---
 rtl/blob_tracker.sv | 245 ++++++++++++++++++++++++
 tb/tb_blob_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/blob_tracker.sv
// blob_tracker: single-pass connected-component tracker over run-length rows.
// Reads run words {marker, start, end} from a FIFO, grows per-slot bounding
// boxes row by row, and emits a box record when a blob stops continuing.
//
// state | meaning
// IDLE  | first cycle out of reset
// FETCH | waiting for a FIFO word, strobes rd_en when one is available
// WAIT  | FIFO data valid, decode the word
// MATCH | attach the run to a slot or allocate a new one
// CLOSE | end of row: retire slots not hit this row, roll spans forward
// FLUSH | end of frame: emit and free every valid slot
// DONE  | pulse frame_done, rewind the row counter
//
// Ports:
//   clk, rst (sync, active-low)
//   empty, fifo_out, rd_en                 run FIFO read side
//   box_valid, box_ready, box_*            record output with valid/ready
//   frame_done                             one-cycle end-of-frame pulse
//   overflow                               sticky, no free slot for a run
module blob_tracker #(
    parameter int COORD_W  = 11,
    parameter int N_BLOBS  = 8,
    parameter int MIN_SIZE = 0,
    parameter int AREA_W   = 2 * COORD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty,
    input  logic [2*COORD_W:0]   fifo_out,
    output logic                 rd_en,
    output logic                 box_valid,
    input  logic                 box_ready,
    output logic [COORD_W-1:0]   box_xmin,
    output logic [COORD_W-1:0]   box_xmax,
    output logic [COORD_W-1:0]   box_ymin,
    output logic [COORD_W-1:0]   box_ymax,
    output logic [AREA_W-1:0]    box_area,
    output logic                 frame_done,
    output logic                 overflow
);
    localparam int IDX_W = (N_BLOBS > 1) ? $clog2(N_BLOBS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BLOBS - 1);
    localparam logic [AREA_W-1:0] MIN_A    = AREA_W'(MIN_SIZE);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, MATCH, CLOSE, FLUSH, DONE} state_t;

    state_t               state;
    logic [COORD_W-1:0]   row;
    logic [IDX_W-1:0]     idx;
    logic [COORD_W-1:0]   run_s, run_e;
    logic                 frame_start;

    logic                 s_valid  [N_BLOBS];
    logic                 s_hit    [N_BLOBS];
    logic [COORD_W-1:0]   s_xmin   [N_BLOBS];
    logic [COORD_W-1:0]   s_xmax   [N_BLOBS];
    logic [COORD_W-1:0]   s_ymin   [N_BLOBS];
    logic [COORD_W-1:0]   s_ymax   [N_BLOBS];
    logic [AREA_W-1:0]    s_area   [N_BLOBS];
    logic [COORD_W-1:0]   s_plo    [N_BLOBS];
    logic [COORD_W-1:0]   s_phi    [N_BLOBS];
    logic [COORD_W-1:0]   s_clo    [N_BLOBS];
    logic [COORD_W-1:0]   s_chi    [N_BLOBS];

    logic                 w_mark;
    logic [COORD_W-1:0]   w_s, w_e;
    logic [COORD_W:0]     run_len;
    logic [AREA_W:0]      area_sum;
    logic                 hit_any, free_any;
    logic [IDX_W-1:0]     hit_idx, free_idx;
    logic                 area_ok, emit_now, adv;

    assign w_mark  = fifo_out[2*COORD_W];
    assign w_s     = fifo_out[2*COORD_W-1:COORD_W];
    assign w_e     = fifo_out[COORD_W-1:0];
    assign run_len = {1'b0, run_e} - {1'b0, run_s} + (COORD_W+1)'(1);
    assign area_sum = {1'b0, s_area[hit_idx]} + (AREA_W+1)'(run_len);

    // rd_en must follow empty in the same cycle so an empty FIFO is never read.
    assign rd_en = (state == FETCH) && !empty;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = N_BLOBS - 1; i >= 0; i--) begin
            if (s_valid[i] && run_s <= s_phi[i] && run_e >= s_plo[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!s_valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    if (MIN_SIZE == 0) begin : g_nomin
        assign area_ok = 1'b1;
    end else begin : g_min
        assign area_ok = (s_area[idx] >= MIN_A);
    end

    // CLOSE retires only slots that missed this row; FLUSH retires all.
    assign emit_now = s_valid[idx] && area_ok && ((state == FLUSH) || !s_hit[idx]);
    // Move to the next slot once any pending record has been accepted.
    assign adv = box_valid ? box_ready : !emit_now;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            row         <= '0;
            idx         <= '0;
            run_s       <= '0;
            run_e       <= '0;
            frame_start <= 1'b1;
            box_valid   <= 1'b0;
            box_xmin    <= '0;
            box_xmax    <= '0;
            box_ymin    <= '0;
            box_ymax    <= '0;
            box_area    <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            for (int i = 0; i < N_BLOBS; i++) begin
                s_valid[i] <= 1'b0;
                s_hit[i]   <= 1'b0;
                s_xmin[i]  <= '0;
                s_xmax[i]  <= '0;
                s_ymin[i]  <= '0;
                s_ymax[i]  <= '0;
                s_area[i]  <= '0;
                s_plo[i]   <= '0;
                s_phi[i]   <= '0;
                s_clo[i]   <= '0;
                s_chi[i]   <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: state <= FETCH;
                FETCH: if (!empty) state <= WAIT;
                WAIT: begin
                    run_s <= w_s;
                    run_e <= w_e;
                    if (!w_mark) begin
                        if (w_s <= w_e) begin
                            if (frame_start) begin
                                overflow    <= 1'b0;
                                frame_start <= 1'b0;
                            end
                            state <= MATCH;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (w_s == '0 && w_e == '0) begin
                        idx   <= '0;
                        state <= CLOSE;
                    end else if (w_s == '0 && w_e == COORD_W'(1)) begin
                        idx   <= '0;
                        state <= FLUSH;
                    end else begin
                        state <= FETCH;
                    end
                end
                MATCH: begin
                    if (hit_any) begin
                        if (run_s < s_xmin[hit_idx]) s_xmin[hit_idx] <= run_s;
                        if (run_e > s_xmax[hit_idx]) s_xmax[hit_idx] <= run_e;
                        s_ymax[hit_idx] <= row;
                        s_area[hit_idx] <= area_sum[AREA_W] ? '1 : area_sum[AREA_W-1:0];
                        // The cur span is stale until the first hit of the row.
                        if (s_hit[hit_idx]) begin
                            if (run_s < s_clo[hit_idx]) s_clo[hit_idx] <= run_s;
                            if (run_e > s_chi[hit_idx]) s_chi[hit_idx] <= run_e;
                        end else begin
                            s_clo[hit_idx] <= run_s;
                            s_chi[hit_idx] <= run_e;
                        end
                        s_hit[hit_idx] <= 1'b1;
                    end else if (free_any) begin
                        s_valid[free_idx] <= 1'b1;
                        s_hit[free_idx]   <= 1'b1;
                        s_xmin[free_idx]  <= run_s;
                        s_xmax[free_idx]  <= run_e;
                        s_ymin[free_idx]  <= row;
                        s_ymax[free_idx]  <= row;
                        s_area[free_idx]  <= AREA_W'(run_len);
                        s_clo[free_idx]   <= run_s;
                        s_chi[free_idx]   <= run_e;
                        // Keep a stale prev span from matching later runs of this row.
                        s_plo[free_idx]   <= run_s;
                        s_phi[free_idx]   <= run_e;
                    end else begin
                        overflow <= 1'b1;
                    end
                    state <= FETCH;
                end
                CLOSE, FLUSH: begin
                    if (box_valid) begin
                        if (box_ready) box_valid <= 1'b0;
                    end else if (s_valid[idx]) begin
                        if (state == CLOSE && s_hit[idx]) begin
                            s_plo[idx] <= s_clo[idx];
                            s_phi[idx] <= s_chi[idx];
                            s_hit[idx] <= 1'b0;
                        end else begin
                            s_valid[idx] <= 1'b0;
                            s_hit[idx]   <= 1'b0;
                            if (emit_now) begin
                                box_valid <= 1'b1;
                                box_xmin  <= s_xmin[idx];
                                box_xmax  <= s_xmax[idx];
                                box_ymin  <= s_ymin[idx];
                                box_ymax  <= s_ymax[idx];
                                box_area  <= s_area[idx];
                            end
                        end
                    end
                    if (adv) begin
                        if (idx == LAST_IDX) begin
                            if (state == CLOSE) begin
                                row   <= row + COORD_W'(1);
                                state <= FETCH;
                            end else begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    row         <= '0;
                    frame_start <= 1'b1;
                    state       <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blob_tracker.sv
// Directed bench for blob_tracker: three instances (default, N_BLOBS=2,
// MIN_SIZE=5) share one run FIFO model; only the selected one sees data.
module tb_blob_tracker;
    localparam int CW = 11;
    localparam int AW = 2 * CW;
    localparam int WW = 2 * CW + 1;
    localparam logic [WW-1:0] NR_W  = {1'b1, {CW{1'b0}}, {CW{1'b0}}};
    localparam logic [WW-1:0] EOF_W = {1'b1, {CW{1'b0}}, CW'(1)};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          box_ready = 1'b1;
    int            sel = 0;
    logic [WW-1:0] fifo_out = '0;
    logic          q_empty = 1'b1;
    logic [WW-1:0] q[$];

    logic          em [3];
    logic          rd [3];
    logic          bv [3];
    logic          fd [3];
    logic          ov [3];
    logic [CW-1:0] xmn [3];
    logic [CW-1:0] xmx [3];
    logic [CW-1:0] ymn [3];
    logic [CW-1:0] ymx [3];
    logic [AW-1:0] ar [3];

    assign em[0] = q_empty || (sel != 0);
    assign em[1] = q_empty || (sel != 1);
    assign em[2] = q_empty || (sel != 2);

    blob_tracker u_dut0 (
        .clk(clk), .rst(rst), .empty(em[0]), .fifo_out(fifo_out), .rd_en(rd[0]),
        .box_valid(bv[0]), .box_ready(box_ready), .box_xmin(xmn[0]), .box_xmax(xmx[0]),
        .box_ymin(ymn[0]), .box_ymax(ymx[0]), .box_area(ar[0]),
        .frame_done(fd[0]), .overflow(ov[0]));

    blob_tracker #(.N_BLOBS(2)) u_dut1 (
        .clk(clk), .rst(rst), .empty(em[1]), .fifo_out(fifo_out), .rd_en(rd[1]),
        .box_valid(bv[1]), .box_ready(box_ready), .box_xmin(xmn[1]), .box_xmax(xmx[1]),
        .box_ymin(ymn[1]), .box_ymax(ymx[1]), .box_area(ar[1]),
        .frame_done(fd[1]), .overflow(ov[1]));

    blob_tracker #(.MIN_SIZE(5)) u_dut2 (
        .clk(clk), .rst(rst), .empty(em[2]), .fifo_out(fifo_out), .rd_en(rd[2]),
        .box_valid(bv[2]), .box_ready(box_ready), .box_xmin(xmn[2]), .box_xmax(xmx[2]),
        .box_ymin(ymn[2]), .box_ymax(ymx[2]), .box_area(ar[2]),
        .frame_done(fd[2]), .overflow(ov[2]));

    // FIFO: data appears on fifo_out the cycle after rd_en.
    always @(posedge clk) begin
        if (rd[sel] && q.size() > 0) fifo_out <= q.pop_front();
        q_empty <= (q.size() == 0);
    end

    logic [4*CW+AW-1:0] rec_q[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rst && bv[sel] && box_ready)
            rec_q.push_back({xmn[sel], xmx[sel], ymn[sel], ymx[sel], ar[sel]});
        if (fd[sel]) done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] run_w(input int s, input int e);
        return {1'b0, CW'(s), CW'(e)};
    endfunction

    function automatic logic [4*CW+AW-1:0] rec(input int xa, input int xb, input int ya,
                                              input int yb, input int a);
        return {CW'(xa), CW'(xb), CW'(ya), CW'(yb), AW'(a)};
    endfunction

    task automatic push(input logic [WW-1:0] w);
        q.push_back(w);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tick(3);
        chk({tag, "_frame_done"}, 80'(done_cnt - start), 80'(1));
    endtask

    task automatic expect_rec(input string tag, input logic [4*CW+AW-1:0] r);
        chk({tag, "_present"}, 80'(rec_q.size() > 0), 80'(1));
        if (rec_q.size() > 0) chk(tag, 80'(rec_q.pop_front()), 80'(r));
    endtask

    initial begin
        int n;
        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_ctl", 80'({rd[0], bv[0], fd[0], ov[0]}), 80'(0));
        chk("rst_box", 80'({xmn[0], xmx[0], ymn[0], ymx[0], ar[0]}), 80'(0));
        tick(1);
        rst = 1'b1;
        tick(2);

        // Vertical blob over three rows
        push(run_w(5, 15)); push(NR_W); push(run_w(5, 15)); push(NR_W);
        push(run_w(5, 15)); push(EOF_W);
        wait_done("t37");
        chk("t37_count", 80'(rec_q.size()), 80'(1));
        expect_rec("t37_rec", rec(5, 15, 0, 2, 33));

        // Two blobs closed on an empty row
        push(run_w(0, 3)); push(run_w(10, 12)); push(NR_W); push(NR_W);
        n = 0;
        while (rec_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
        tick(5);
        chk("t38_count", 80'(rec_q.size()), 80'(2));
        expect_rec("t38_rec0", rec(0, 3, 0, 0, 4));
        expect_rec("t38_rec1", rec(10, 12, 0, 0, 3));
        push(EOF_W);
        wait_done("t38");
        chk("t38_flush_empty", 80'(rec_q.size()), 80'(0));

        // Slot overflow with N_BLOBS=2
        sel = 1;
        tick(2);
        push(run_w(0, 1)); push(run_w(3, 4)); push(run_w(6, 7));
        tick(30);
        @(negedge clk);
        chk("t39_ovf_set", 80'(ov[1]), 80'(1));
        tick(1);
        push(EOF_W);
        wait_done("t39");
        chk("t39_count", 80'(rec_q.size()), 80'(2));
        expect_rec("t39_rec0", rec(0, 1, 0, 0, 2));
        expect_rec("t39_rec1", rec(3, 4, 0, 0, 2));
        @(negedge clk);
        chk("t39_ovf_sticky", 80'(ov[1]), 80'(1));
        tick(1);
        push(run_w(0, 0));
        tick(10);
        @(negedge clk);
        chk("t39_ovf_clear", 80'(ov[1]), 80'(0));
        tick(1);
        push(EOF_W);
        wait_done("t39b");
        expect_rec("t39_rec2", rec(0, 0, 0, 0, 1));

        // MIN_SIZE=5: area 3 dropped, area 5 kept
        sel = 2;
        tick(2);
        push(run_w(2, 4)); push(EOF_W);
        wait_done("t40");
        chk("t40_none", 80'(rec_q.size()), 80'(0));
        push(run_w(0, 4)); push(EOF_W);
        wait_done("t40b");
        chk("t40b_count", 80'(rec_q.size()), 80'(1));
        expect_rec("t40_min_edge", rec(0, 4, 0, 0, 5));

        // Back-pressure during FLUSH
        sel = 0;
        tick(2);
        box_ready = 1'b0;
        push(run_w(1, 2)); push(EOF_W);
        n = 0;
        while (!bv[0] && n < 300) begin @(negedge clk); n++; end
        chk("t41_valid", 80'(bv[0]), 80'(1));
        push(run_w(0, 0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t41_hold_box", 80'({bv[0], xmn[0], xmx[0], ymn[0], ymx[0], ar[0]}),
                80'({1'b1, rec(1, 2, 0, 0, 2)}));
            chk("t41_hold_rd", 80'(rd[0]), 80'(0));
        end
        @(posedge clk);
        #1 box_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t41_released", 80'(bv[0]), 80'(0));
        chk("t41_count", 80'(rec_q.size()), 80'(1));
        expect_rec("t41_rec", rec(1, 2, 0, 0, 2));
        wait_done("t41");
        push(EOF_W);
        wait_done("t41b");
        expect_rec("t41_rec2", rec(0, 0, 0, 0, 1));

        // Reset mid-row with two live slots
        push(run_w(0, 3)); push(run_w(8, 9));
        tick(15);
        rst = 1'b0;
        tick(2);
        @(negedge clk);
        chk("t42_rst_ctl", 80'({rd[0], bv[0], fd[0], ov[0]}), 80'(0));
        chk("t42_rst_box", 80'({xmn[0], xmx[0], ymn[0], ymx[0], ar[0]}), 80'(0));
        tick(1);
        rst = 1'b1;
        push(run_w(4, 6)); push(EOF_W);
        wait_done("t42");
        chk("t42_count", 80'(rec_q.size()), 80'(1));
        expect_rec("t42_rec", rec(4, 6, 0, 0, 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
